sprinkler_valve_driver: RTL and testbench

- Sits between the sprinkler FSM's valve commands (`valve_A_open`, `valve_B_open`) and the two solenoid coil outputs.
- Converts each level command into a solenoid drive profile: full-on pull-in, then PWM hold.
- Enforces a hardware interlock: never both coils driven, with a dead time between valves.
- Flags contradictory commands.

---
 rtl/sprinkler_valve_driver.sv | 75 +++++++
 tb/tb_sprinkler_valve_driver.sv | 113 +++++++++++
 2 files changed

// File: rtl/sprinkler_valve_driver.sv
// sprinkler_valve_driver: interlocked two-solenoid driver with pull-in, PWM hold and dead time.
// SPRINKLER_VALVE_FAULT_LATCH_EN makes conflict sticky and forces both coils off until reset.
module sprinkler_valve_driver #(
  parameter int PULL_IN_CYCLES = 20,
  parameter int PWM_PERIOD     = 16,
  parameter int HOLD_DUTY      = 6,
  parameter int DEAD_CYCLES    = 8,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_a_open,
  input  logic cmd_b_open,
  output logic coil_a,
  output logic coil_b,
  output logic a_active,
  output logic b_active,
  output logic conflict
);
  typedef enum logic [2:0] {IDLE, PULL_A, HOLD_A, PULL_B, HOLD_B, DEAD} state_t;
  localparam logic [CNT_W-1:0] PULL_LAST = CNT_W'(PULL_IN_CYCLES - 1);
  localparam logic [CNT_W-1:0] PWM_LAST  = CNT_W'(PWM_PERIOD - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DUTY_LAST = CNT_W'(HOLD_DUTY - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] timer, timer_n, pwm, pwm_n;
  logic a, b, halt, conflict_n, hold_n, duty_on;
  assign a = cmd_a_open;
  assign b = cmd_b_open;
`ifdef SPRINKLER_VALVE_FAULT_LATCH_EN
  assign conflict_n = conflict | (a & b);
  assign halt = conflict;
`else
  assign conflict_n = a & b;
  assign halt = 1'b0;
`endif
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = halt ? IDLE : (a & !b) ? PULL_A : (b & !a) ? PULL_B : IDLE;
      PULL_A:  state_n = (!a || halt) ? DEAD : (timer == PULL_LAST) ? HOLD_A : PULL_A;
      HOLD_A:  state_n = (!a || halt) ? DEAD : HOLD_A;
      PULL_B:  state_n = (!b || halt) ? DEAD : (timer == PULL_LAST) ? HOLD_B : PULL_B;
      HOLD_B:  state_n = (!b || halt) ? DEAD : HOLD_B;
      DEAD:    state_n = (timer == DEAD_LAST) ? IDLE : DEAD;
      default: state_n = IDLE;
    endcase
    hold_n  = (state_n == HOLD_A) || (state_n == HOLD_B);
    timer_n = (state_n != state) ? '0 : (&timer) ? timer : timer + 1'b1;
    pwm_n   = (hold_n && state_n == state) ? ((pwm == PWM_LAST) ? '0 : pwm + 1'b1) : '0;
    // a zero duty must never drive, so it cannot rely on the DUTY_LAST compare
    duty_on = (HOLD_DUTY != 0) && (pwm_n <= DUTY_LAST);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      pwm      <= '0;
      coil_a   <= 1'b0;
      coil_b   <= 1'b0;
      a_active <= 1'b0;
      b_active <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      pwm      <= pwm_n;
      coil_a   <= (state_n == PULL_A) || (state_n == HOLD_A && duty_on);
      coil_b   <= (state_n == PULL_B) || (state_n == HOLD_B && duty_on);
      a_active <= (state_n == PULL_A) || (state_n == HOLD_A);
      b_active <= (state_n == PULL_B) || (state_n == HOLD_B);
      conflict <= conflict_n;
    end
  end
endmodule

// File: tb/tb_sprinkler_valve_driver.sv
// tb_sprinkler_valve_driver: directed scoreboard bench for sprinkler_valve_driver.
module tb_sprinkler_valve_driver;
  logic clk = 1'b0, rst_n = 1'b0, cmd_a = 1'b0, cmd_b = 1'b0;
  logic coil_a, coil_b, a_active, b_active, conflict;
  logic z_a, z_b, z_aa, z_ba, z_cf, f_a, f_b, f_aa, f_ba, f_cf;
  int total = 0, bad = 0;
  typedef struct {
    logic [4:0] v;
    string tag;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  sprinkler_valve_driver dut (.clk(clk), .rst_n(rst_n), .cmd_a_open(cmd_a), .cmd_b_open(cmd_b),
    .coil_a(coil_a), .coil_b(coil_b), .a_active(a_active), .b_active(b_active), .conflict(conflict));
  sprinkler_valve_driver #(.HOLD_DUTY(0)) dut_zero (.clk(clk), .rst_n(rst_n), .cmd_a_open(cmd_a),
    .cmd_b_open(cmd_b), .coil_a(z_a), .coil_b(z_b), .a_active(z_aa), .b_active(z_ba), .conflict(z_cf));
  sprinkler_valve_driver #(.HOLD_DUTY(16)) dut_full (.clk(clk), .rst_n(rst_n), .cmd_a_open(cmd_a),
    .cmd_b_open(cmd_b), .coil_a(f_a), .coil_b(f_b), .a_active(f_aa), .b_active(f_ba), .conflict(f_cf));

  always @(negedge clk) begin
    total++;
    assert (((coil_a & coil_b) | (z_a & z_b) | (f_a & f_b)) === 1'b0) else begin
      bad++;
      $error("FAIL exclusive got=%b%b%b%b%b%b exp=no pair high", coil_a, coil_b, z_a, z_b, f_a, f_b);
    end
  end

  task automatic check(input logic [4:0] got, input logic [4:0] want, input string tag);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, want);
    end
  endtask

  task automatic run(input int n, input logic [4:0] want, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      q.push_back('{want, tag});
      @(posedge clk);
      #1;
      e = q.pop_front();
      check({coil_a, coil_b, a_active, b_active, conflict}, e.v, e.tag);
    end
  endtask

  task automatic hold_a(input int n);
    for (int i = 0; i < n; i++) begin
      run(1, {((i % 16) < 6) ? 1'b1 : 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}, "hold_a");
      check({z_a, f_a}, 2'b01, "duty_corner");
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    check({coil_a, coil_b, a_active, b_active, conflict}, 5'b0, "reset");
    rst_n = 1'b1;
    run(2, 5'b00000, "idle");
    cmd_a = 1'b1;
    run(20, 5'b10100, "pull_a");
    hold_a(32);
    rst_n = 1'b0;
    #1;
    check({coil_a, coil_b, a_active, b_active, conflict}, 5'b0, "reset_mid_hold");
    check({z_a, f_a, z_aa, f_aa}, 4'b0, "reset_mid_hold_corners");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(20, 5'b10100, "pull_a_again");
    hold_a(20);
    cmd_a = 1'b0;
    cmd_b = 1'b1;
    run(9, 5'b00000, "handover_dead");
    run(20, 5'b01010, "pull_b");
    run(1, 5'b01010, "hold_b_first");
    cmd_b = 1'b0;
    run(9, 5'b00000, "dead_b");
    cmd_b = 1'b1;
    run(3, 5'b01010, "short_pull");
    cmd_b = 1'b0;
    run(8, 5'b00000, "short_dead");
    run(3, 5'b00000, "short_idle");
    cmd_a = 1'b1;
    cmd_b = 1'b1;
    run(3, 5'b00001, "conflict");
    cmd_b = 1'b0;
`ifdef SPRINKLER_VALVE_FAULT_LATCH_EN
    run(5, 5'b00001, "conflict_latched");
    cmd_a = 1'b0;
    run(4, 5'b00001, "latched_idle");
    cmd_a = 1'b1;
    run(4, 5'b00001, "latched_refuse");
    cmd_a = 1'b0;
`else
    run(20, 5'b10100, "conflict_release_pull");
    run(1, 5'b10100, "conflict_release_hold");
    cmd_a = 1'b0;
    run(9, 5'b00000, "release_dead");
`endif
    rst_n = 1'b0;
    #1;
    check({coil_a, coil_b, a_active, b_active, conflict}, 5'b0, "final_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(2, 5'b00000, "final_idle");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
